// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg
//   Shared definitions for the SDRAM request arbiter in front of sdrc_core's
//   app_* port: FSM state encoding, request-length width and the default
//   burst / guard / fairness settings.
package sdram_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_GUARD   = 3'd3,
        ST_WR_REQ  = 3'd4,
        ST_WR_DATA = 3'd5
    } arb_state_t;

    localparam int LEN_W          = 9;
    localparam int RD_LEN_DEF     = 8;
    localparam int GUARD_CYC_DEF  = 2;
    localparam int MAX_RD_RUN_DEF = 4;

    // Counter width that can hold the value n itself (at least 1 bit).
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sdram_req_arbiter.sv
// sdram_req_arbiter
//   One arbitration stage in front of sdrc_core's app_* port. Merges video
//   refresh burst reads and single-word FTDI writes into one request stream,
//   follows each read burst to its last beat and holds off writes for a
//   bus-turnaround guard afterwards. Reads have priority, but after
//   MAX_RD_RUN consecutive read grants with a write waiting, the write wins.
//
// Ports
//   clk, reset_n                       memory clock (w_mem_clk), sync active-low reset
//   rd_req_i, rd_addr_i, rd_ack_o      video read request / burst address / accept pulse
//   wr_req_i, wr_addr_i, wr_data_i     FTDI write request / address / data
//   wr_ack_o                           write word consumed pulse
//   app_req_o, app_req_addr_o,
//   app_req_len_o, app_req_wr_n_o,
//   app_wr_data_o                      request towards sdrc_core
//   app_req_ack_i, app_wr_next_i,
//   app_rd_valid_i, app_last_rd_i      handshakes from sdrc_core
//   busy_o                             arbiter not idle
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no transaction, arbitrate between read and write requests
// ST_RD_REQ  | read burst request presented, waiting for app_req_ack_i
// ST_RD_DATA | burst accepted, counting beats until last / RD_LEN
// ST_GUARD   | bus turnaround, GUARD_CYC cycles, beats ignored
// ST_WR_REQ  | single-word write request presented, waiting for ack
// ST_WR_DATA | write accepted, waiting for app_wr_next_i
module sdram_req_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int AW         = 25,
    parameter int DW         = 16,
    parameter int RD_LEN     = RD_LEN_DEF,
    parameter int GUARD_CYC  = GUARD_CYC_DEF,
    parameter int MAX_RD_RUN = MAX_RD_RUN_DEF
) (
    input  logic             clk,
    input  logic             reset_n,

    input  logic             rd_req_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic             rd_ack_o,

    input  logic             wr_req_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [DW-1:0]    wr_data_i,
    output logic             wr_ack_o,

    output logic             app_req_o,
    output logic [AW-1:0]    app_req_addr_o,
    output logic [LEN_W-1:0] app_req_len_o,
    output logic             app_req_wr_n_o,
    output logic [DW-1:0]    app_wr_data_o,
    input  logic             app_req_ack_i,
    input  logic             app_wr_next_i,
    input  logic             app_rd_valid_i,
    input  logic             app_last_rd_i,

    output logic             busy_o
);

    localparam int BEAT_W  = cnt_w(RD_LEN);
    localparam int GUARD_W = cnt_w(GUARD_CYC);
    localparam int RUN_W   = cnt_w(MAX_RD_RUN);

    localparam logic [BEAT_W-1:0]  BEAT_LAST  = BEAT_W'(RD_LEN);
    localparam logic [GUARD_W-1:0] GUARD_LOAD = GUARD_W'(GUARD_CYC);
    localparam logic [RUN_W-1:0]   RUN_MAX    = RUN_W'(MAX_RD_RUN);

    arb_state_t         state;
    logic [BEAT_W-1:0]  beat_cnt;
    logic [GUARD_W-1:0] guard_cnt;
    logic [RUN_W-1:0]   run_cnt;

    logic               write_wins;
    logic               burst_done;

    // A waiting write only overtakes reads once the read run has saturated.
    assign write_wins = wr_req_i && (run_cnt == RUN_MAX);

    assign burst_done = app_last_rd_i ||
                        (app_rd_valid_i && ((beat_cnt + BEAT_W'(1)) == BEAT_LAST));

    // Acks are combinational so the requester sees them in the handshake cycle;
    // gating with reset_n keeps them quiet while reset is being applied.
    assign rd_ack_o = reset_n && (state == ST_RD_REQ) && app_req_ack_i;
    assign wr_ack_o = reset_n && app_wr_next_i &&
                      (((state == ST_WR_REQ) && app_req_ack_i) || (state == ST_WR_DATA));

    assign busy_o = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            app_req_o      <= 1'b0;
            app_req_addr_o <= '0;
            app_req_len_o  <= '0;
            app_req_wr_n_o <= 1'b1;
            app_wr_data_o  <= '0;
            beat_cnt       <= '0;
            guard_cnt      <= '0;
            run_cnt        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!wr_req_i) begin
                        run_cnt <= '0;
                    end
                    if (rd_req_i && !write_wins) begin
                        state          <= ST_RD_REQ;
                        app_req_o      <= 1'b1;
                        app_req_addr_o <= rd_addr_i;
                        app_req_len_o  <= LEN_W'(RD_LEN);
                        app_req_wr_n_o <= 1'b1;
                    end else if (wr_req_i) begin
                        state          <= ST_WR_REQ;
                        app_req_o      <= 1'b1;
                        app_req_addr_o <= wr_addr_i;
                        app_req_len_o  <= LEN_W'(1);
                        app_req_wr_n_o <= 1'b0;
                        app_wr_data_o  <= wr_data_i;
                        run_cnt        <= '0;
                    end
                end

                ST_RD_REQ: begin
                    if (app_req_ack_i) begin
                        state     <= ST_RD_DATA;
                        app_req_o <= 1'b0;
                        beat_cnt  <= '0;
                        if (!wr_req_i) begin
                            run_cnt <= '0;
                        end else if (run_cnt != RUN_MAX) begin
                            run_cnt <= run_cnt + RUN_W'(1);
                        end
                    end
                end

                ST_RD_DATA: begin
                    if (app_rd_valid_i) begin
                        beat_cnt <= beat_cnt + BEAT_W'(1);
                    end
                    if (burst_done) begin
                        if (GUARD_CYC == 0) begin
                            state <= ST_IDLE;
                        end else begin
                            state     <= ST_GUARD;
                            guard_cnt <= GUARD_LOAD;
                        end
                    end
                end

                // Stays here for exactly GUARD_CYC cycles.
                ST_GUARD: begin
                    if (guard_cnt <= GUARD_W'(1)) begin
                        guard_cnt <= '0;
                        state     <= ST_IDLE;
                    end else begin
                        guard_cnt <= guard_cnt - GUARD_W'(1);
                    end
                end

                ST_WR_REQ: begin
                    if (app_req_ack_i) begin
                        app_req_o <= 1'b0;
                        state     <= app_wr_next_i ? ST_IDLE : ST_WR_DATA;
                    end
                end

                ST_WR_DATA: begin
                    if (app_wr_next_i) begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    app_req_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
